// File: rtl/dm_access_ctrl_pkg.sv
// dm_access_ctrl_pkg: op/state encodings, byte-enable constants and access-size helpers.
package dm_access_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB
    } op_t;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_BYTE = 4'b0001;

    function automatic logic is_store(op_t op);
        return op inside {OP_SW, OP_SH, OP_SB};
    endfunction

    function automatic logic is_word(op_t op);
        return op inside {OP_LW, OP_SW};
    endfunction

    function automatic logic is_half(op_t op);
        return op inside {OP_LH, OP_LHU, OP_SH};
    endfunction

    function automatic logic aligned(op_t op, logic [1:0] a);
        return is_word(op) ? a == 2'b00 : is_half(op) ? !a[0] : 1'b1;
    endfunction

    function automatic logic [3:0] be_of(op_t op, logic [1:0] a);
        return is_word(op) ? BE_WORD : is_half(op) ? (a[1] ? BE_HI : BE_LO) : BE_BYTE << a;
    endfunction

    function automatic logic [31:0] lanes(op_t op, logic [31:0] w);
        return is_word(op) ? w : is_half(op) ? {2{w[15:0]}} : {4{w[7:0]}};
    endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// dm_access_ctrl_if: req/ack data-memory bus between the MEM-stage initiator and memory.
interface dm_access_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/dm_access_ctrl_load_ext.sv
// dm_load_ext: selects the load lane from a memory word and sign/zero-extends it.
module dm_load_ext
    import dm_access_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  op_t         op,
    output logic [31:0] rdata
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        rdata = op == OP_LB  ? {{24{b[7]}}, b} :
                op == OP_LBU ? {24'b0, b} :
                op == OP_LH  ? {{16{h[15]}}, h} :
                op == OP_LHU ? {16'b0, h} : word;
    end
endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MEM-stage load/store initiator with alignment checks, req/ack
// handshake to variable-latency memory, load extension and pipeline stall.
module dm_access_ctrl
    import dm_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_type,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        adel,
    output logic        ades,
    output logic        bus_err,
    dm_access_ctrl_if.master mem
);
    state_t           state;
    op_t              op_in;
    op_t              op_q;
    logic [1:0]       lane_q;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      ext;
    logic             ok;
    logic             bad;
    logic             unused_pc;

    assign op_in     = op_t'(op_type);
    assign ok        = aligned(op_in, addr[1:0]);
    assign bad       = state == S_IDLE && op_valid && !ok;
    assign adel      = bad && !is_store(op_in);
    assign ades      = bad && is_store(op_in);
    assign stall     = state == S_BUSY || (state == S_IDLE && op_valid && ok);
    assign unused_pc = ^pc;

    dm_load_ext u_ext (.word(mem.rdata), .lane(lane_q), .op(op_q), .rdata(ext));

    // Extended load data is registered on ack so rdata is stable throughout DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            op_q        <= OP_LW;
            lane_q      <= '0;
            cnt         <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
            mem.req     <= 1'b0;
            mem.we      <= 1'b0;
            mem.addr    <= '0;
            mem.be      <= '0;
            mem.wdata   <= '0;
        end else begin
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
            case (state)
                S_IDLE: if (op_valid && ok) begin
                    state     <= S_BUSY;
                    op_q      <= op_in;
                    lane_q    <= addr[1:0];
                    cnt       <= '0;
                    mem.req   <= 1'b1;
                    mem.we    <= is_store(op_in);
                    mem.addr  <= {addr[31:2], 2'b00};
                    mem.be    <= be_of(op_in, addr[1:0]);
                    mem.wdata <= lanes(op_in, wdata);
                end
                S_BUSY: if (mem.ack || cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state       <= S_DONE;
                    mem.req     <= 1'b0;
                    rdata_valid <= 1'b1;
                    bus_err     <= !mem.ack;
                    rdata       <= (mem.ack && !mem.we) ? ext : '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
